branch_ckpt_ctrl: RTL and testbench

BRANCH_CKPT_CTRL -- requirements
Module: branch_ckpt_ctrl

---
 rtl/branch_ckpt_ctrl_pkg.sv | 29 ++
 rtl/branch_ckpt_ctrl_if.sv | 54 +++++
 rtl/priority_encoder.sv | 37 +++
 rtl/branch_ckpt_ctrl.sv | 169 ++++++++++++++++
 tb/tb_branch_ckpt_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_ckpt_ctrl_pkg.sv
// Shared types for the branch checkpoint controller.
//   ckpt_state_e : controller FSM states (IDLE, RECOVER)
//   ckpt_slot_t  : one checkpoint slot (valid, resolved, ds, id)
//   sat_inc32    : saturating 32-bit increment. It is used by the optional
//                  statistics counters, which are built only when
//                  BRANCH_CKPT_STATS_EN is defined.
package branch_ckpt_ctrl_pkg;

  // Widest active-list id a slot can hold. Narrower ids are zero-extended
  // into this field, so the upper bits are constant and get trimmed.
  localparam int CKPT_ID_W = 16;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } ckpt_state_e;

  typedef struct packed {
    logic                 valid;
    logic                 resolved;
    logic                 ds;
    logic [CKPT_ID_W-1:0] id;
  } ckpt_slot_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_ckpt_ctrl_if.sv
// Bus between the rename stage and the branch checkpoint controller.
//   master : the rename stage / branch unit side. It drives alloc_* and resolve_*.
//   slave  : the controller side. It drives the grant, the slot status,
//            recovery and stall.
// When BRANCH_CKPT_STATS_EN is defined, the slave side also drives
// stat_miss_cnt and stat_full_cycles.
interface branch_ckpt_ctrl_if #(
  parameter int BRANCH_NUM             = 4,
  parameter int BRANCH_NUM_INDEX       = 2,
  parameter int ACTIVE_LIST_SIZE_INDEX = 6
);
  import branch_ckpt_ctrl_pkg::*;

  logic                              alloc_req;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0] alloc_branch_id;
  logic                              alloc_ds_valid;
  logic                              alloc_grant;
  logic [BRANCH_NUM_INDEX-1:0]       alloc_idx;
  logic                              resolve_valid;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0] resolve_branch_id;
  logic                              resolve_miss;
  logic [BRANCH_NUM-1:0]             ckpt_valid;
  logic [BRANCH_NUM-1:0]             ckpt_ds_valid;
  logic                              recover_valid;
  logic [BRANCH_NUM_INDEX-1:0]       recover_idx;
  logic                              stall_rename;
`ifdef BRANCH_CKPT_STATS_EN
  logic [31:0]                       stat_miss_cnt;
  logic [31:0]                       stat_full_cycles;
`else
  // Statistics disabled: no counter signals on the bus.
`endif

  modport master (
    output alloc_req, alloc_branch_id, alloc_ds_valid,
    output resolve_valid, resolve_branch_id, resolve_miss,
    input  alloc_grant, alloc_idx, ckpt_valid, ckpt_ds_valid,
    input  recover_valid, recover_idx, stall_rename
`ifdef BRANCH_CKPT_STATS_EN
    , input stat_miss_cnt, stat_full_cycles
`endif
  );

  modport slave (
    input  alloc_req, alloc_branch_id, alloc_ds_valid,
    input  resolve_valid, resolve_branch_id, resolve_miss,
    output alloc_grant, alloc_idx, ckpt_valid, ckpt_ds_valid,
    output recover_valid, recover_idx, stall_rename
`ifdef BRANCH_CKPT_STATS_EN
    , output stat_miss_cnt, stat_full_cycles
`endif
  );

endinterface

// File: rtl/priority_encoder.sv
// Generic priority encoder.
//   req   : request vector
//   valid : at least one request bit is set
//   idx   : index of the winning bit. The lowest set bit wins when
//           bottom_up=1; the highest set bit wins otherwise.
module priority_encoder #(
  parameter int WIDTH     = 4,
  parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  parameter bit bottom_up = 1'b1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  assign valid = |req;

  generate
    if (bottom_up) begin : g_low_first
      // Scan downwards so the lowest set bit is the last assignment.
      always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (req[i]) idx = IDX_W'(i);
        end
      end
    end else begin : g_high_first
      always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (req[i]) idx = IDX_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint controller.
// Checkpoint slots are kept as a circular buffer. The buffer has a head
// pointer (oldest slot), a tail pointer (next free slot) and an occupancy
// count. Branches are allocated at the tail. Resolved branches retire from
// the head in order. A mispredict squashes every slot younger than the
// mispredicted branch and starts a one-cycle RECOVER pulse.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : branch_ckpt_ctrl_if.slave. It carries alloc_*, resolve_*,
//                ckpt_valid/ckpt_ds_valid, recover_valid/recover_idx and
//                stall_rename.
// Optional build macro BRANCH_CKPT_STATS_EN adds two saturating 32-bit
// counters: stat_miss_cnt and stat_full_cycles.
module branch_ckpt_ctrl
  import branch_ckpt_ctrl_pkg::*;
#(
  parameter int BRANCH_NUM             = 4,
  parameter int BRANCH_NUM_INDEX       = 2,
  parameter int ACTIVE_LIST_SIZE_INDEX = 6
) (
  input logic               clk,
  input logic               rst_n,
  branch_ckpt_ctrl_if.slave bus
);

  localparam int CW = BRANCH_NUM_INDEX + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BRANCH_NUM);

  ckpt_slot_t                  slot_reg [BRANCH_NUM];
  logic [BRANCH_NUM_INDEX-1:0] head_reg;
  logic [BRANCH_NUM_INDEX-1:0] tail_reg;
  logic [CW-1:0]               count_reg;
  ckpt_state_e                 state_reg;
  logic                        recover_valid_reg;
  logic [BRANCH_NUM_INDEX-1:0] recover_idx_reg;

  logic [BRANCH_NUM-1:0]       match_vec;
  logic [BRANCH_NUM-1:0]       valid_vec;
  logic [BRANCH_NUM-1:0]       ds_vec;
  logic                        match_found;
  logic [BRANCH_NUM_INDEX-1:0] match_idx;
  logic [BRANCH_NUM_INDEX-1:0] miss_depth;
  logic [CKPT_ID_W-1:0]        resolve_id_ext;
  logic [CKPT_ID_W-1:0]        alloc_id_ext;
  logic full, take_hit, take_miss, grant, retire;

  assign resolve_id_ext = CKPT_ID_W'(bus.resolve_branch_id);
  assign alloc_id_ext   = CKPT_ID_W'(bus.alloc_branch_id);

  generate
    for (genvar gi = 0; gi < BRANCH_NUM; gi++) begin : g_slot
      assign match_vec[gi] = slot_reg[gi].valid && (slot_reg[gi].id == resolve_id_ext);
      assign valid_vec[gi] = slot_reg[gi].valid;
      assign ds_vec[gi]    = slot_reg[gi].ds;
    end
  endgenerate

  // When several live slots carry the same id, the lowest slot index wins.
  priority_encoder #(
    .WIDTH     (BRANCH_NUM),
    .IDX_W     (BRANCH_NUM_INDEX),
    .bottom_up (1'b1)
  ) u_match_enc (
    .req   (match_vec),
    .valid (match_found),
    .idx   (match_idx)
  );

  assign full      = (count_reg == CNT_FULL);
  assign take_hit  = bus.resolve_valid && match_found && !bus.resolve_miss && (state_reg == IDLE);
  assign take_miss = bus.resolve_valid && match_found &&  bus.resolve_miss && (state_reg == IDLE);
  // The full check uses the count before any same-cycle retire.
  assign grant = bus.alloc_req && !full && (state_reg == IDLE) &&
                 !(bus.resolve_valid && bus.resolve_miss && match_found);
  // The mispredicted slot survives recovery, so it must not retire in the
  // same cycle.
  assign retire = slot_reg[head_reg].valid && slot_reg[head_reg].resolved &&
                  !(take_miss && (match_idx == head_reg));
  // Age of the mispredicted slot relative to the head. Modulo-N wrap gives
  // the circular distance.
  assign miss_depth = match_idx - head_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      recover_valid_reg <= 1'b0;
      recover_idx_reg   <= '0;
      for (int i = 0; i < BRANCH_NUM; i++) slot_reg[i] <= '0;
    end else begin
      // Squash every slot younger than the mispredicted one. Slots are
      // ranked by their distance from the head.
      for (int i = 0; i < BRANCH_NUM; i++) begin
        if (take_miss && ((BRANCH_NUM_INDEX'(i) - head_reg) > miss_depth)) slot_reg[i] <= '0;
      end
      if (take_hit)  slot_reg[match_idx].resolved <= 1'b1;
      if (take_miss) slot_reg[match_idx].resolved <= 1'b0;
      if (retire)    slot_reg[head_reg] <= '0;
      // The grant target is always a free slot. A grant never coincides with
      // a squash, and a free slot is never the retiring head.
      if (grant) begin
        slot_reg[tail_reg].valid    <= 1'b1;
        slot_reg[tail_reg].resolved <= 1'b0;
        slot_reg[tail_reg].ds       <= bus.alloc_ds_valid;
        slot_reg[tail_reg].id       <= alloc_id_ext;
      end

      if (retire) head_reg <= head_reg + BRANCH_NUM_INDEX'(1);

      if (take_miss) begin
        tail_reg  <= match_idx + BRANCH_NUM_INDEX'(1);
        count_reg <= {1'b0, miss_depth} + CW'(1) - CW'(retire);
      end else begin
        if (grant) tail_reg <= tail_reg + BRANCH_NUM_INDEX'(1);
        count_reg <= count_reg + CW'(grant) - CW'(retire);
      end

      case (state_reg)
        IDLE: begin
          if (take_miss) begin
            state_reg         <= RECOVER;
            recover_valid_reg <= 1'b1;
            recover_idx_reg   <= match_idx;
          end else begin
            recover_valid_reg <= 1'b0;
          end
        end
        RECOVER: begin
          state_reg         <= IDLE;
          recover_valid_reg <= 1'b0;
        end
        default: begin
          state_reg         <= IDLE;
          recover_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alloc_grant   = grant;
  assign bus.alloc_idx     = tail_reg;
  assign bus.ckpt_valid    = valid_vec;
  assign bus.ckpt_ds_valid = ds_vec;
  assign bus.recover_valid = recover_valid_reg;
  assign bus.recover_idx   = recover_idx_reg;
  assign bus.stall_rename  = full || (state_reg == RECOVER);

`ifdef BRANCH_CKPT_STATS_EN
  logic [31:0] stat_miss_cnt_reg;
  logic [31:0] stat_full_cycles_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_miss_cnt_reg    <= '0;
      stat_full_cycles_reg <= '0;
    end else begin
      if (take_miss)             stat_miss_cnt_reg    <= sat_inc32(stat_miss_cnt_reg);
      if (bus.alloc_req && full) stat_full_cycles_reg <= sat_inc32(stat_full_cycles_reg);
    end
  end

  assign bus.stat_miss_cnt    = stat_miss_cnt_reg;
  assign bus.stat_full_cycles = stat_full_cycles_reg;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// Self-checking bench for branch_ckpt_ctrl.
// The reference model keeps live branches as an age-ordered queue plus a
// head slot number. Slot numbers and all expected outputs are derived from
// that queue.
module tb_branch_ckpt_ctrl;

  localparam int N  = 4;
  localparam int BI = 2;
  localparam int AI = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_ckpt_ctrl_if #(.BRANCH_NUM(N), .BRANCH_NUM_INDEX(BI), .ACTIVE_LIST_SIZE_INDEX(AI)) bus ();

  branch_ckpt_ctrl #(.BRANCH_NUM(N), .BRANCH_NUM_INDEX(BI), .ACTIVE_LIST_SIZE_INDEX(AI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AI-1:0] id;
    logic          ds;
    logic          res;
  } ent_t;

  ent_t q[$];
  int   m_head  = 0;
  bit   m_rec   = 1'b0;
  int   m_recix = 0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input int k);
    return (m_head + k) % N;
  endfunction

  // Queue position of the matching branch that sits in the lowest slot
  // number, or -1 when there is no match.
  function automatic int find_match(input logic [AI-1:0] rid);
    int best = N;
    int pos  = -1;
    foreach (q[k]) begin
      if (q[k].id == rid && slot_of(k) < best) begin
        best = slot_of(k);
        pos  = k;
      end
    end
    return pos;
  endfunction

  // Runs one clock cycle, starting and ending just after a falling edge.
  task automatic step(input logic req, input logic [AI-1:0] aid, input logic ads,
                      input logic rv, input logic [AI-1:0] rid, input logic rm,
                      input logic rstn, input bit check);
    int pos;
    int mslot;
    bit take;
    bit miss;
    bit ret;
    bit g;
    logic [N-1:0] ev;
    logic [N-1:0] eds;
    ent_t e;
    bus.alloc_req         = req;
    bus.alloc_branch_id   = aid;
    bus.alloc_ds_valid    = ads;
    bus.resolve_valid     = rv;
    bus.resolve_branch_id = rid;
    bus.resolve_miss      = rm;
    rst_n                 = rstn;
    #1;
    pos = find_match(rid);
    g   = req && (q.size() < N) && !m_rec && !(rv && rm && pos >= 0);
    if (check) begin
      ev  = '0;
      eds = '0;
      foreach (q[k]) begin
        ev[slot_of(k)]  = 1'b1;
        eds[slot_of(k)] = q[k].ds;
      end
      chk("alloc_grant",   32'(bus.alloc_grant),   32'(g));
      chk("alloc_idx",     32'(bus.alloc_idx),     32'((m_head + q.size()) % N));
      chk("ckpt_valid",    32'(bus.ckpt_valid),    32'(ev));
      chk("ckpt_ds_valid", 32'(bus.ckpt_ds_valid), 32'(eds));
      chk("recover_valid", 32'(bus.recover_valid), 32'(m_rec));
      if (m_rec) chk("recover_idx", 32'(bus.recover_idx), 32'(m_recix));
      chk("stall_rename",  32'(bus.stall_rename),  32'((q.size() == N) || m_rec));
    end
    @(posedge clk);
    if (!rstn) begin
      q.delete();
      m_head  = 0;
      m_rec   = 1'b0;
      m_recix = 0;
    end else begin
      take  = rv && !m_rec && (pos >= 0);
      miss  = take && rm;
      mslot = (pos >= 0) ? slot_of(pos) : 0;
      ret   = (q.size() > 0) && q[0].res && !(miss && pos == 0);
      if (take && !rm) q[pos].res = 1'b1;
      if (miss) begin
        while (q.size() > pos + 1) void'(q.pop_back());
        q[pos].res = 1'b0;
      end
      if (ret) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % N;
      end
      if (g) begin
        e.id  = aid;
        e.ds  = ads;
        e.res = 1'b0;
        q.push_back(e);
      end
      m_rec = miss;
      if (miss) m_recix = mslot;
    end
    @(negedge clk);
  endtask

  task automatic alloc(input logic [AI-1:0] id, input logic ds);
    step(1'b1, id, ds, 1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic resolve(input logic [AI-1:0] id, input logic miss);
    step(1'b0, '0, 1'b0, 1'b1, id, miss, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          r_req;
    logic          r_ads;
    logic          r_rv;
    logic          r_rm;
    logic          r_rstn;
    logic [AI-1:0] r_aid;
    logic [AI-1:0] r_rid;

    // Reset, then check the reset state.
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("reset_recover_idx", 32'(bus.recover_idx), 32'd0);
    chk("reset_ckpt_valid",  32'(bus.ckpt_valid),  32'd0);

    // Fill the buffer, then try one more allocation.
    alloc(6'd3, 1'b0);
    alloc(6'd5, 1'b1);
    alloc(6'd7, 1'b0);
    alloc(6'd9, 1'b1);
    chk("fill_valid", 32'(bus.ckpt_valid),   32'hF);
    chk("fill_stall", 32'(bus.stall_rename), 32'd1);
    alloc(6'd11, 1'b0);
    chk("fill_no_write", 32'(bus.ckpt_valid), 32'hF);
    chk("fill_idx",      32'(bus.alloc_idx),  32'd0);

    // Out-of-order resolve and in-order retire.
    resolve(6'd7, 1'b0);
    resolve(6'd3, 1'b0);
    idle();
    chk("ooo_slot0_retired", 32'(bus.ckpt_valid), 32'hE);
    idle();
    chk("ooo_slot2_waits",   32'(bus.ckpt_valid), 32'hE);
    resolve(6'd5, 1'b0);
    idle();
    chk("ooo_slot1_retired", 32'(bus.ckpt_valid), 32'hC);
    idle();
    chk("ooo_slot2_retired", 32'(bus.ckpt_valid), 32'h8);
    resolve(6'd9, 1'b0);
    idle();
    chk("ooo_empty", 32'(bus.ckpt_valid), 32'h0);

    // Mispredict in the middle of a full buffer.
    alloc(6'd3, 1'b0);
    alloc(6'd5, 1'b0);
    alloc(6'd7, 1'b0);
    alloc(6'd9, 1'b0);
    resolve(6'd5, 1'b1);
    chk("miss_recover_valid", 32'(bus.recover_valid), 32'd1);
    chk("miss_recover_idx",   32'(bus.recover_idx),   32'd1);
    chk("miss_valid",         32'(bus.ckpt_valid),    32'h3);
    chk("miss_tail",          32'(bus.alloc_idx),     32'd2);
    idle();
    chk("miss_pulse_end", 32'(bus.recover_valid), 32'd0);

    // Mispredict in the same cycle as an allocation request.
    step(1'b1, 6'd20, 1'b1, 1'b1, 6'd3, 1'b1, 1'b1, 1'b1);
    chk("miss_alloc_valid", 32'(bus.ckpt_valid), 32'h1);
    chk("miss_alloc_tail",  32'(bus.alloc_idx),  32'd1);
    idle();

    // Wrap: head=3, tail=1, mispredict on slot 3.
    resolve(6'd3, 1'b0);
    idle();
    alloc(6'd20, 1'b0);
    alloc(6'd21, 1'b0);
    resolve(6'd20, 1'b0);
    resolve(6'd21, 1'b0);
    idle();
    alloc(6'd40, 1'b1);
    alloc(6'd41, 1'b1);
    chk("wrap_pre_valid", 32'(bus.ckpt_valid), 32'h9);
    chk("wrap_pre_tail",  32'(bus.alloc_idx),  32'd1);
    resolve(6'd40, 1'b1);
    chk("wrap_valid",       32'(bus.ckpt_valid),    32'h8);
    chk("wrap_tail",        32'(bus.alloc_idx),     32'd0);
    chk("wrap_recover_idx", 32'(bus.recover_idx),   32'd3);
    idle();

    // Reset during RECOVER.
    alloc(6'd42, 1'b0);
    resolve(6'd42, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_rec_valid",   32'(bus.ckpt_valid),    32'h0);
    chk("rst_rec_recover", 32'(bus.recover_valid), 32'd0);
    chk("rst_rec_idx",     32'(bus.recover_idx),   32'd0);
    chk("rst_rec_stall",   32'(bus.stall_rename),  32'd0);
    chk("rst_rec_tail",    32'(bus.alloc_idx),     32'd0);
    alloc(6'd50, 1'b1);
    chk("rst_rec_alloc_valid", 32'(bus.ckpt_valid),    32'h1);
    chk("rst_rec_alloc_ds",    32'(bus.ckpt_ds_valid), 32'h1);

    // Randomized traffic checked against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      r_req  = ($urandom_range(0, 99) < 55);
      r_aid  = AI'($urandom_range(0, 15));
      r_ads  = 1'($urandom_range(0, 1));
      r_rv   = ($urandom_range(0, 99) < 45);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        r_rid = q[$urandom_range(0, q.size() - 1)].id;
      else
        r_rid = AI'($urandom_range(0, 15));
      r_rm   = ($urandom_range(0, 99) < 15);
      r_rstn = ($urandom_range(0, 199) != 0);
      step(r_req, r_aid, r_ads, r_rv, r_rid, r_rm, r_rstn, 1'b1);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
